// File: rtl/latch_gate_driver.sv
`default_nettype none
// ============================================================================
// Module   : latch_gate_driver
// Purpose  : Write-side sequencer for arrays of transparent-high latch cells.
//            Takes one write request at a time on a valid/ready handshake,
//            drives the shared latch D bus, then pulses exactly one per-word
//            gate line so D is stable SETUP_CYC cycles before the gate opens
//            and HOLD_CYC cycles after it closes. All gate lines come straight
//            from flops, so they are glitch-free.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1       clock, rising edge
//   rst_n        in   1       asynchronous reset, active low
//   req_valid_i  in   1       write request valid
//   req_ready_o  out  1       controller idle and able to accept
//   req_addr_i   in   ADDR_W  target word
//   req_data_i   in   DATA_W  data to store
//   lat_d_o      out  DATA_W  shared latch D bus
//   lat_g_o      out  WORDS   per-word latch gates, one-hot or zero
//   busy_o       out  1       write sequence in progress
//   done_o       out  1       one-cycle pulse when a sequence finishes
//   err_o        out  1       pulses with done_o when the address was >= WORDS
// ============================================================================
module latch_gate_driver #(
    parameter int DATA_W    = 8,
    parameter int WORDS     = 4,
    parameter int ADDR_W    = 2,
    parameter int SETUP_CYC = 1,
    parameter int GATE_CYC  = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_data_i,
    output logic [DATA_W-1:0] lat_d_o,
    output logic [WORDS-1:0]  lat_g_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    // One shared down-counter serves all three timed phases, so it is sized
    // for the longest of them.
    localparam int CNT_MAX_SG = (SETUP_CYC > GATE_CYC) ? SETUP_CYC : GATE_CYC;
    localparam int CNT_MAX    = (CNT_MAX_SG > HOLD_CYC) ? CNT_MAX_SG : HOLD_CYC;
    localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] GATE_LD  = CNT_W'(GATE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_OPEN  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   lat_d_q, lat_d_d;
    logic [WORDS-1:0]    lat_g_q, lat_g_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                accept;
    logic                cnt_zero;
    logic                addr_in_range;
    logic [WORDS-1:0]    gate_dec;

    assign accept   = req_valid_i && (state_q == ST_IDLE);
    assign cnt_zero = (cnt_q == '0);

    // Widened compare: stays meaningful when WORDS == 2**ADDR_W.
    assign addr_in_range = (32'(addr_q) < 32'(WORDS));

    // Address decode; an out-of-range address matches no line, so the
    // decode is naturally all-zero in that case.
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_gate_dec
        assign gate_dec[gi] = (32'(addr_q) == 32'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            lat_d_q <= '0;
            lat_g_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            lat_d_q <= lat_d_d;
            lat_g_q <= lat_g_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        lat_d_d = lat_d_q;
        lat_g_d = lat_g_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // lat_d only ever changes here, so it cannot move while a
                // gate is open or during the hold window.
                if (accept) begin
                    lat_d_d = req_data_i;
                    addr_d  = req_addr_i;
                    cnt_d   = SETUP_LD;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    lat_g_d = gate_dec;
                    cnt_d   = GATE_LD;
                    state_d = ST_OPEN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_OPEN: begin
                if (cnt_zero) begin
                    lat_g_d = '0;
                    cnt_d   = HOLD_LD;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    done_d  = 1'b1;
                    err_d   = !addr_in_range;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                lat_g_d = '0;
            end
        endcase
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign lat_d_o     = lat_d_q;
    assign lat_g_o     = lat_g_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_latch_gate_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_latch_gate_driver
// Purpose  : Directed self-checking bench for latch_gate_driver. Three
//            instances: A (defaults), B (SETUP=2 GATE=3 HOLD=2),
//            C (WORDS=3). Shadow latch arrays model the latch cells.
// Revision : 1.0 - initial release
// ============================================================================
module tb_latch_gate_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A: defaults ----------------
    logic       va, ra, busy_a, done_a, err_a;
    logic [1:0] adr_a;
    logic [7:0] dat_a, ld_a;
    logic [3:0] lg_a;
    latch_gate_driver u_a (
        .clk(clk), .rst_n(rst_n), .req_valid_i(va), .req_ready_o(ra),
        .req_addr_i(adr_a), .req_data_i(dat_a), .lat_d_o(ld_a), .lat_g_o(lg_a),
        .busy_o(busy_a), .done_o(done_a), .err_o(err_a));

    // ---------------- DUT B: longer timing ----------------
    logic       vb, rb, busy_b, done_b, err_b;
    logic [1:0] adr_b;
    logic [7:0] dat_b, ld_b;
    logic [3:0] lg_b;
    latch_gate_driver #(.DATA_W(8), .WORDS(4), .ADDR_W(2),
                        .SETUP_CYC(2), .GATE_CYC(3), .HOLD_CYC(2)) u_b (
        .clk(clk), .rst_n(rst_n), .req_valid_i(vb), .req_ready_o(rb),
        .req_addr_i(adr_b), .req_data_i(dat_b), .lat_d_o(ld_b), .lat_g_o(lg_b),
        .busy_o(busy_b), .done_o(done_b), .err_o(err_b));

    // ---------------- DUT C: three words ----------------
    logic       vc, rc, busy_c, done_c, err_c;
    logic [1:0] adr_c;
    logic [7:0] dat_c, ld_c;
    logic [2:0] lg_c;
    latch_gate_driver #(.DATA_W(8), .WORDS(3), .ADDR_W(2)) u_c (
        .clk(clk), .rst_n(rst_n), .req_valid_i(vc), .req_ready_o(rc),
        .req_addr_i(adr_c), .req_data_i(dat_c), .lat_d_o(ld_c), .lat_g_o(lg_c),
        .busy_o(busy_c), .done_o(done_c), .err_o(err_c));

    // ---------------- shadow latch cells ----------------
    logic [7:0] mem_a [4];
    logic [7:0] mem_b [4];
    always @(lg_a or ld_a) for (int i = 0; i < 4; i++) if (lg_a[i]) mem_a[i] = ld_a;
    always @(lg_b or ld_b) for (int i = 0; i < 4; i++) if (lg_b[i]) mem_b[i] = ld_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- monitors: one-hot, D stability, counters ----------------
    int         gate_cnt_a [4] = '{default: 0};
    int         gate_cnt_b [4] = '{default: 0};
    int         gate_cnt_c [3] = '{default: 0};
    int         done_cnt_a = 0;
    logic       open_a = 1'b0, open_b = 1'b0, open_c = 1'b0;
    int         win_a = 0, win_b = 0, win_c = 0;
    logic [7:0] ref_a = '0, ref_b = '0, ref_c = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            open_a <= 1'b0;
            win_a  <= 0;
        end else begin
            check("onehot_a", 32'($onehot0(lg_a)), 32'd1);
            if (open_a || win_a > 0) check("stable_a", 32'(ld_a), 32'(ref_a));
            if (lg_a != '0 && !open_a) ref_a <= ld_a;
            open_a <= (lg_a != '0);
            win_a  <= (lg_a != '0) ? 1 : ((win_a > 0) ? win_a - 1 : 0);
            if (done_a) done_cnt_a <= done_cnt_a + 1;
            for (int i = 0; i < 4; i++) gate_cnt_a[i] <= gate_cnt_a[i] + int'(lg_a[i]);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            open_b <= 1'b0;
            win_b  <= 0;
        end else begin
            check("onehot_b", 32'($onehot0(lg_b)), 32'd1);
            if (open_b || win_b > 0) check("stable_b", 32'(ld_b), 32'(ref_b));
            if (lg_b != '0 && !open_b) ref_b <= ld_b;
            open_b <= (lg_b != '0);
            win_b  <= (lg_b != '0) ? 2 : ((win_b > 0) ? win_b - 1 : 0);
            for (int i = 0; i < 4; i++) gate_cnt_b[i] <= gate_cnt_b[i] + int'(lg_b[i]);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            open_c <= 1'b0;
            win_c  <= 0;
        end else begin
            check("onehot_c", 32'($onehot0(lg_c)), 32'd1);
            if (open_c || win_c > 0) check("stable_c", 32'(ld_c), 32'(ref_c));
            if (lg_c != '0 && !open_c) ref_c <= ld_c;
            open_c <= (lg_c != '0);
            win_c  <= (lg_c != '0) ? 1 : ((win_c > 0) ? win_c - 1 : 0);
            for (int i = 0; i < 3; i++) gate_cnt_c[i] <= gate_cnt_c[i] + int'(lg_c[i]);
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    int k, acc0, acc1, d0, d1;

    initial begin
        // 1: reset with random inputs
        rst_n = 1'b0;
        va = 1'b1; adr_a = 2'($urandom); dat_a = 8'($urandom);
        vb = 1'b1; adr_b = 2'($urandom); dat_b = 8'($urandom);
        vc = 1'b1; adr_c = 2'($urandom); dat_c = 8'($urandom);
        step(3);
        check("rst_ld_a",   32'(ld_a),   32'h0);
        check("rst_lg_a",   32'(lg_a),   32'h0);
        check("rst_done_a", 32'(done_a), 32'h0);
        check("rst_err_a",  32'(err_a),  32'h0);
        check("rst_ready_a",32'(ra),     32'h1);
        check("rst_busy_a", 32'(busy_a), 32'h0);
        check("rst_lg_b",   32'(lg_b),   32'h0);
        check("rst_ready_b",32'(rb),     32'h1);
        check("rst_ld_c",   32'(ld_c),   32'h0);
        check("rst_lg_c",   32'(lg_c),   32'h0);
        va = 1'b0; vb = 1'b0; vc = 1'b0;
        rst_n = 1'b1;
        step(1);
        check("idle_ready_a", 32'(ra),   32'h1);
        check("idle_ld_a",    32'(ld_a), 32'h0);

        // 2: single write on defaults, addr 2 data A5
        va = 1'b1; adr_a = 2'd2; dat_a = 8'hA5;
        step(1);                               // edge 0: accepted
        va = 1'b0;
        check("t2_ld_e0",    32'(ld_a),   32'hA5);
        check("t2_lg_e0",    32'(lg_a),   32'h0);
        check("t2_busy_e0",  32'(busy_a), 32'h1);
        check("t2_ready_e0", 32'(ra),     32'h0);
        step(1);                               // edge 1
        check("t2_lg_e1",    32'(lg_a),   32'h4);
        step(1);                               // edge 2
        check("t2_lg_e2",    32'(lg_a),   32'h0);
        check("t2_done_e2",  32'(done_a), 32'h0);
        check("t2_ld_e2",    32'(ld_a),   32'hA5);
        step(1);                               // edge 3
        check("t2_done_e3",  32'(done_a), 32'h1);
        check("t2_err_e3",   32'(err_a),  32'h0);
        check("t2_ready_e3", 32'(ra),     32'h1);
        check("t2_mem",      32'(mem_a[2]), 32'hA5);
        step(1);
        check("t2_done_e4",  32'(done_a), 32'h0);
        check("t2_gcnt2",    32'(gate_cnt_a[2]), 32'd1);

        // 4: request while busy is ignored
        d0 = done_cnt_a;
        va = 1'b1; adr_a = 2'd0; dat_a = 8'h3C;
        step(1);                               // edge 0
        va = 1'b0;
        step(1);                               // edge 1: OPEN
        check("t4_lg_open", 32'(lg_a), 32'h1);
        va = 1'b1; adr_a = 2'd1; dat_a = 8'hFF;
        step(1);                               // edge 2
        va = 1'b0;
        check("t4_ready_hold", 32'(ra),   32'h0);
        check("t4_lg_hold",    32'(lg_a), 32'h0);
        check("t4_ld_hold",    32'(ld_a), 32'h3C);
        step(1);                               // edge 3
        check("t4_done", 32'(done_a), 32'h1);
        step(3);
        check("t4_busy_after", 32'(busy_a), 32'h0);
        check("t4_ld_after",   32'(ld_a),   32'h3C);
        check("t4_gcnt1",      32'(gate_cnt_a[1]), 32'd0);
        check("t4_done_count", 32'(done_cnt_a - d0), 32'd1);
        check("t4_mem0",       32'(mem_a[0]), 32'h3C);

        // 3: back-to-back writes on B with valid held
        vb = 1'b1; adr_b = 2'd0; dat_b = 8'h11;
        k = 0;
        while (!rb && k < 20) begin step(1); k++; end
        check("t3_ready1", 32'(rb), 32'h1);
        step(1);
        acc0 = cyc;
        adr_b = 2'd3; dat_b = 8'h22;
        k = 0;
        while (!rb && k < 20) begin step(1); k++; end
        check("t3_ready2", 32'(rb), 32'h1);
        step(1);
        acc1 = cyc;
        vb = 1'b0;
        check("t3_spacing", 32'(acc1 - acc0), 32'd8);
        check("t3_ld2",     32'(ld_b), 32'h22);
        k = 0;
        while (!done_b && k < 20) begin step(1); k++; end
        check("t3_done", 32'(done_b), 32'h1);
        step(2);
        check("t3_gcnt0", 32'(gate_cnt_b[0]), 32'd3);
        check("t3_gcnt3", 32'(gate_cnt_b[3]), 32'd3);
        check("t3_mem0",  32'(mem_b[0]), 32'h11);
        check("t3_mem3",  32'(mem_b[3]), 32'h22);
        check("t3_busy",  32'(busy_b), 32'h0);

        // 5: out-of-range address on C
        vc = 1'b1; adr_c = 2'd3; dat_c = 8'h5A;
        step(1);
        vc = 1'b0;
        check("t5_busy", 32'(busy_c), 32'h1);
        check("t5_ld",   32'(ld_c),   32'h5A);
        k = 0;
        while (!done_c && k < 20) begin step(1); k++; end
        check("t5_latency", 32'(k), 32'd3);
        check("t5_done",    32'(done_c), 32'h1);
        check("t5_err",     32'(err_c),  32'h1);
        step(1);
        check("t5_err_off", 32'(err_c), 32'h0);
        check("t5_gates",   32'(gate_cnt_c[0] + gate_cnt_c[1] + gate_cnt_c[2]), 32'd0);

        // 6: reset during OPEN
        va = 1'b1; adr_a = 2'd1; dat_a = 8'h77;
        step(1);
        va = 1'b0;
        step(1);
        check("t6_lg_open", 32'(lg_a), 32'h2);
        #1 rst_n = 1'b0;
        #1;
        check("t6_lg_async",   32'(lg_a),   32'h0);
        check("t6_busy_async", 32'(busy_a), 32'h0);
        step(2);
        rst_n = 1'b1;
        d1 = done_cnt_a;
        step(5);
        check("t6_no_done", 32'(done_cnt_a - d1), 32'd0);
        check("t6_ready",   32'(ra), 32'h1);
        va = 1'b1; adr_a = 2'd3; dat_a = 8'h99;
        step(1);
        va = 1'b0;
        step(3);
        check("t6_done2", 32'(done_a), 32'h1);
        check("t6_mem3",  32'(mem_a[3]), 32'h99);
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
